mem_bist: RTL and testbench
===========================

Name: mem_bist

Overview:
- Parametrised successor to the fixed 8x32 memory pair: a single synchronous-write, combinational-read word memory with a built-in self-test (BIST) controller.
- On `start`, the controller runs a four-pass march: write pattern, read/compare, write inverted pattern, read/compare.
- It reports pass/fail, first-failure capture and a saturating error count.
- When idle, the memory is reachable through an external port. The block sits beside the datapath memories as their verification/bring-up wrapper.

Parameters:
- DATA_W, 32, word width in bits (>=4).
- DEPTH, 8, number of words (>=2, any integer, need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).
- SEED, 32'hc0000001, constant pattern for mode 0 (truncated/zero-extended to DATA_W).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE
- mode  in  2  pattern select, latched at start
- ext_we  in  1  external write enable; honoured only when busy=0
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_rdata  out  DATA_W  combinational read of mem[ext_addr] (always, fault hook applied)
- fault_en  in  1  test hook: corrupt reads at fault_addr
- fault_addr  in  ADDR_W  corrupted address
- fault_mask  in  DATA_W  XOR mask applied to read data
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  sticky: last test found no error
- fail  out  1  sticky: last test found >=1 error
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  read data at first mismatch
- fail_phase  out  1  0 = true-pattern pass, 1 = inverted pass
- err_count  out  ERR_W  mismatches, saturating at all-ones

Behaviour:
- Reset (async, rst_n=0):
  - FSM -> IDLE; all outputs listed above except ext_rdata -> 0.
  - Memory contents are NOT reset.
- Memory:
  - Write on rising clk when the selected write enable is high.
  - Read is combinational.
  - Read data = mem[a] ^ (fault_en && a==fault_addr ? fault_mask : 0).
  - Address >= DEPTH: writes ignored, read returns 0.
- FSM states: IDLE, W0, R0, W1, R1, DONE.
- IDLE -> W0 on start:
  - Clears pass, fail, err_count, fail_addr, fail_data, fail_phase.
  - Latches mode; addr counter = 0.
  - busy=1 from the next cycle.
- Pass timing:
  - W0/W1: one write per cycle, addr 0..DEPTH-1; on DEPTH-1, go to next state with addr=0.
  - R0/R1: compare read data against expected each cycle; result registered at the same edge the address advances.
  - Mismatch: err_count += 1 (saturate). If fail was 0, set fail=1 and capture addr, read data and phase (R0=0, R1=1).
- R1 at DEPTH-1 -> DONE:
  - In DONE: busy=0, done=1 for one cycle, pass = ~fail; then IDLE.
  - busy is high for exactly 4*DEPTH cycles.
- Expected pattern P(addr):
  - mode 0: SEED
  - mode 1: checkerboard, {DATA_W/2{2'b01}}, inverted when addr[0]=1
  - mode 2: addr zero-extended to DATA_W
  - mode 3: walking one, 1 << (addr % DATA_W)
  - Phases W1/R1 use ~P(addr).
- Busy-time rules:
  - start while busy or in DONE: ignored.
  - ext_we while busy: ignored (BIST owns the write port).
- Reset mid-test: immediate return to IDLE, no done pulse, memory left partially written.
- After a passing test, memory holds ~P(addr) at every address.

Decomposition:
- Package mem_bist_pkg:
  - state enum (IDLE, W0, R0, W1, R1, DONE)
  - mode constants (MODE_SEED, MODE_CHECK, MODE_ADDR, MODE_WALK)
  - pattern function pat(mode, addr, inv), parameterised by width through the caller.
- Sub-module mem_array (DATA_W, DEPTH):
  - storage with one write port and two combinational read ports.
  - Fault XOR applied in mem_bist, not in mem_array.

Test Plan (DATA_W=32, DEPTH=8 unless stated):
1. Assert rst_n=0 with random inputs -> busy, done, pass, fail, err_count, fail_* all 0. ext_we at addr 2 with 32'h12345678 -> ext_rdata=32'h12345678 next cycle.
2. Start, mode 0, no fault -> busy high for exactly 32 cycles; done pulses once on cycle 33; pass=1, fail=0, err_count=0. ext_addr=3 then reads 32'h3ffffffe.
3. Start, mode 2, fault_en=1, fault_addr=5, fault_mask=32'h1:
   - fail=1, pass=0, fail_addr=5, fail_data=32'h4, fail_phase=0, err_count=2.
   - With fault_en=0 afterwards, ext_rdata at addr 5 = 32'hfffffffa.
4. During a mode-1 run: pulse start and ext_we (addr 0, 32'hdeadbeef) at cycle 10 -> no restart; total busy still 32 cycles; pass=1; addr 0 holds 32'haaaaaaaa.
5. Reset mid-run: drop rst_n during W1 (cycle 20) -> busy=0 immediately, done never pulses. Restart completes normally with pass=1.
6. DATA_W=8, DEPTH=16, ERR_W=1, mode 3, fault_en, fault_addr=9, fault_mask=8'hff:
   - Expected at addr 9 = 8'h02; fail_data=8'hfd.
   - err_count saturates at 1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types, mode codes and the march pattern generator for mem_bist.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0   = 3'd2,
    W1   = 3'd3,
    R1   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_SEED  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  // Widest data word the pattern generator can serve; callers truncate.
  localparam int PAT_MAX_W = 128;
  typedef logic [PAT_MAX_W-1:0] pat_t;

  // Expected word for an address; bits at and above 'width' are forced to 0
  // so the caller can simply truncate to its own data width.
  function automatic pat_t pat(input logic [1:0]  mode,
                               input logic [31:0] addr,
                               input logic        inv,
                               input int          width,
                               input logic [31:0] seed);
    pat_t p;
    pat_t keep;
    int   walk_pos;
    p        = '0;
    keep     = '0;
    walk_pos = int'(addr % $unsigned(width));
    case (mode)
      MODE_SEED: begin
        p = pat_t'(seed);
      end
      MODE_CHECK: begin
        // Even bit positions set, odd top bit left clear for odd widths.
        for (int i = 0; i < PAT_MAX_W; i++) begin
          p[i] = ((i % 2) == 0) && (i < 2 * (width / 2));
        end
        if (addr[0]) begin
          p = ~p;
        end else begin
          p = p;
        end
      end
      MODE_ADDR: begin
        p = pat_t'(addr);
      end
      MODE_WALK: begin
        for (int i = 0; i < PAT_MAX_W; i++) begin
          p[i] = (i == walk_pos);
        end
      end
      default: begin
        p = '0;
      end
    endcase
    if (inv) begin
      p = ~p;
    end else begin
      p = p;
    end
    for (int i = 0; i < PAT_MAX_W; i++) begin
      keep[i] = (i < width);
    end
    return p & keep;
  endfunction

endpackage

// File: rtl/mem_bist_mem_array.sv
// Word storage: one synchronous write port, two combinational read ports.
// Out-of-range addresses drop writes and read back as zero. Not reset.
module mem_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Synchronous write of in-range addresses only.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational reads, zero for addresses past the last word.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if ({1'b0, raddr_a} < DEPTH_L) begin
      rdata_a = mem_r[raddr_a];
    end else begin
      rdata_a = '0;
    end
    if ({1'b0, raddr_b} < DEPTH_L) begin
      rdata_b = mem_r[raddr_b];
    end else begin
      rdata_b = '0;
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Memory with built-in four-pass march self-test (write P, read P,
// write ~P, read ~P). External port owns the memory while not busy.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter  int          DATA_W = 32,
  parameter  int          DEPTH  = 8,
  parameter  logic [31:0] SEED   = 32'hc0000001,
  parameter  int          ERR_W  = 8,
  localparam int          ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  input  logic              fault_en,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic [DATA_W-1:0] fault_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              fail_phase,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic [1:0]        mode_r, mode_next_s;
  logic              busy_next_s, done_next_s, pass_next_s, fail_next_s;
  logic              fail_phase_next_s;
  logic [ADDR_W-1:0] fail_addr_next_s;
  logic [DATA_W-1:0] fail_data_next_s;
  logic [ERR_W-1:0]  err_count_next_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] ext_raw_s, bist_raw_s, bist_rdata_s, exp_s;
  logic              inv_s, mismatch_s, at_last_s;

  // Test hook: flip selected bits when reading the chosen address.
  function automatic logic [DATA_W-1:0] apply_fault(input logic [DATA_W-1:0] raw,
                                                    input logic [ADDR_W-1:0] a,
                                                    input logic              en,
                                                    input logic [ADDR_W-1:0] fa,
                                                    input logic [DATA_W-1:0] mask);
    logic [DATA_W-1:0] r;
    if (en && (a == fa)) begin
      r = raw ^ mask;
    end else begin
      r = raw;
    end
    return r;
  endfunction

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we_s),
    .waddr   (mem_waddr_s),
    .wdata   (mem_wdata_s),
    .raddr_a (ext_addr),
    .rdata_a (ext_raw_s),
    .raddr_b (addr_r),
    .rdata_b (bist_raw_s)
  );

  // Expected pattern for the current march step and faulted read data.
  always_comb begin
    inv_s        = (state_r == W1) || (state_r == R1);
    exp_s        = DATA_W'(pat(mode_r, 32'(addr_r), inv_s, DATA_W, SEED));
    ext_rdata    = apply_fault(ext_raw_s, ext_addr, fault_en, fault_addr, fault_mask);
    bist_rdata_s = apply_fault(bist_raw_s, addr_r, fault_en, fault_addr, fault_mask);
    mismatch_s   = (bist_rdata_s != exp_s);
    at_last_s    = (addr_r == LAST_ADDR);
  end

  // Write-port ownership: BIST during write passes, external when not busy.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = ext_addr;
    mem_wdata_s = ext_wdata;
    case (state_r)
      W0, W1: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = addr_r;
        mem_wdata_s = exp_s;
      end
      IDLE, DONE: begin
        mem_we_s = ext_we;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // March sequencing, result capture and next-state decode.
  always_comb begin
    state_next_s      = state_r;
    addr_next_s       = addr_r;
    mode_next_s       = mode_r;
    pass_next_s       = pass;
    fail_next_s       = fail;
    fail_addr_next_s  = fail_addr;
    fail_data_next_s  = fail_data;
    fail_phase_next_s = fail_phase;
    err_count_next_s  = err_count;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s      = W0;
          addr_next_s       = '0;
          mode_next_s       = mode;
          pass_next_s       = 1'b0;
          fail_next_s       = 1'b0;
          fail_addr_next_s  = '0;
          fail_data_next_s  = '0;
          fail_phase_next_s = 1'b0;
          err_count_next_s  = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      W0, W1: begin
        if (at_last_s) begin
          addr_next_s  = '0;
          state_next_s = (state_r == W0) ? R0 : R1;
        end else begin
          addr_next_s = addr_r + ADDR_W'(1);
        end
      end
      R0, R1: begin
        if (mismatch_s) begin
          if (err_count != {ERR_W{1'b1}}) begin
            err_count_next_s = err_count + ERR_W'(1);
          end else begin
            err_count_next_s = err_count;
          end
          if (!fail) begin
            fail_next_s       = 1'b1;
            fail_addr_next_s  = addr_r;
            fail_data_next_s  = bist_rdata_s;
            fail_phase_next_s = (state_r == R1);
          end else begin
            fail_next_s = fail;
          end
        end else begin
          err_count_next_s = err_count;
        end
        if (at_last_s) begin
          addr_next_s = '0;
          if (state_r == R0) begin
            state_next_s = W1;
          end else begin
            state_next_s = DONE;
            pass_next_s  = ~fail_next_s;
          end
        end else begin
          addr_next_s = addr_r + ADDR_W'(1);
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s == W0) || (state_next_s == R0) ||
                  (state_next_s == W1) || (state_next_s == R1);
    done_next_s = (state_next_s == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      mode_r     <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_phase <= 1'b0;
      err_count  <= '0;
    end else begin
      state_r    <= state_next_s;
      addr_r     <= addr_next_s;
      mode_r     <= mode_next_s;
      busy       <= busy_next_s;
      done       <= done_next_s;
      pass       <= pass_next_s;
      fail       <= fail_next_s;
      fail_addr  <= fail_addr_next_s;
      fail_data  <= fail_data_next_s;
      fail_phase <= fail_phase_next_s;
      err_count  <= err_count_next_s;
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: directed scenarios plus randomized
// runs compared against an array/loop reference model of the march test.
module tb_mem_bist;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int DW8 = 8;
  localparam int DEPTH8 = 16;
  localparam int AW8 = 4;
  localparam logic [31:0] SEED = 32'hc0000001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, ext_we, fault_en, busy, done, pass, fail, fail_phase;
  logic [1:0]    mode;
  logic [AW-1:0] ext_addr, fault_addr, fail_addr;
  logic [DW-1:0] ext_wdata, ext_rdata, fault_mask, fail_data;
  logic [7:0]    err_count;

  logic           start8, ext_we8, fault_en8, busy8, done8, pass8, fail8, fail_phase8;
  logic [1:0]     mode8;
  logic [AW8-1:0] ext_addr8, fault_addr8, fail_addr8;
  logic [DW8-1:0] ext_wdata8, ext_rdata8, fault_mask8, fail_data8;
  logic [0:0]     err_count8;

  mem_bist #(.DATA_W(DW), .DEPTH(DEPTH), .SEED(SEED), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .fault_en(fault_en), .fault_addr(fault_addr), .fault_mask(fault_mask),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_addr(fail_addr),
    .fail_data(fail_data), .fail_phase(fail_phase), .err_count(err_count)
  );

  mem_bist #(.DATA_W(DW8), .DEPTH(DEPTH8), .SEED(SEED), .ERR_W(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .ext_we(ext_we8),
    .ext_addr(ext_addr8), .ext_wdata(ext_wdata8), .ext_rdata(ext_rdata8),
    .fault_en(fault_en8), .fault_addr(fault_addr8), .fault_mask(fault_mask8),
    .busy(busy8), .done(done8), .pass(pass8), .fail(fail8), .fail_addr(fail_addr8),
    .fail_data(fail_data8), .fail_phase(fail_phase8), .err_count(err_count8)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int done8_cnt = 0;
  logic [31:0] ref_mem [DEPTH];

  // Count done pulses of both instances, sampled on the falling edge.
  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done8) done8_cnt <= done8_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference pattern straight from the pattern rules.
  function automatic logic [63:0] ref_pat(input int width, input int m, input int a,
                                          input bit inv, input logic [31:0] seed);
    logic [63:0] wmask;
    logic [63:0] v;
    wmask = (64'd1 << width) - 64'd1;
    case (m)
      0: v = {32'd0, seed};
      1: begin
        v = 64'h5555_5555_5555_5555 & wmask;
        if (width % 2 == 1) v[width-1] = 1'b0;
        if (a % 2 == 1) v = ~v;
      end
      2: v = 64'(a);
      default: v = 64'd1 << (a % width);
    endcase
    if (inv) v = ~v;
    return v & wmask;
  endfunction

  // Whole-test outcome: faults only disturb reads, so each read sees P^fault.
  task automatic model_run(input int width, input int depth, input int errw, input int m,
                           input bit fen, input int fa, input logic [63:0] fm,
                           output bit efail, output int eaddr, output logic [63:0] edata,
                           output bit ephase, output int eerr);
    logic [63:0] expv;
    logic [63:0] rd;
    logic [63:0] wmask;
    wmask = (64'd1 << width) - 64'd1;
    efail = 1'b0; eaddr = 0; edata = 64'd0; ephase = 1'b0; eerr = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < depth; a++) begin
        expv = ref_pat(width, m, a, ph[0], SEED);
        rd = expv ^ ((fen && a == fa) ? (fm & wmask) : 64'd0);
        if (rd != expv) begin
          if (eerr < (1 << errw) - 1) eerr++;
          if (!efail) begin
            efail = 1'b1; eaddr = a; edata = rd; ephase = ph[0];
          end
        end
      end
    end
  endtask

  task automatic run32(input int m, input bit fen, input int fa, input logic [31:0] fm,
                       input int inject);
    int cnt; int base; bit efail; int eaddr; logic [63:0] edata; bit ephase; int eerr;
    logic [63:0] tmp;
    fault_en = fen; fault_addr = AW'(fa); fault_mask = fm; mode = 2'(m);
    ext_we = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_rise", busy, 64'd1);
    base = done_cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == inject) begin
        start = 1'b1; ext_we = 1'b1; ext_addr = '0; ext_wdata = 32'hdeadbeef;
      end else begin
        start = 1'b0; ext_we = 1'b0;
      end
      step();
      cnt++;
    end
    start = 1'b0; ext_we = 1'b0;
    check_eq("busy_cycles", 64'(cnt), 64'(4 * DEPTH));
    check_eq("done_at_end", done, 64'd1);
    model_run(DW, DEPTH, 8, m, fen, fa, 64'(fm), efail, eaddr, edata, ephase, eerr);
    check_eq("pass", pass, 64'(!efail));
    check_eq("fail", fail, 64'(efail));
    check_eq("fail_addr", fail_addr, 64'(eaddr));
    check_eq("fail_data", fail_data, edata);
    check_eq("fail_phase", fail_phase, 64'(ephase));
    check_eq("err_count", err_count, 64'(eerr));
    step();
    check_eq("done_low", done, 64'd0);
    check_eq("done_once", 64'(done_cnt - base), 64'd1);
    for (int a = 0; a < DEPTH; a++) begin
      tmp = ref_pat(DW, m, a, 1'b1, SEED);
      ref_mem[a] = tmp[31:0];
    end
  endtask

  task automatic run8(input int m, input bit fen, input int fa, input logic [7:0] fm);
    int cnt; bit efail; int eaddr; logic [63:0] edata; bit ephase; int eerr;
    fault_en8 = fen; fault_addr8 = AW8'(fa); fault_mask8 = fm; mode8 = 2'(m);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    cnt = 0;
    while (busy8 && cnt < 200) begin
      step();
      cnt++;
    end
    check_eq("busy8_cycles", 64'(cnt), 64'(4 * DEPTH8));
    check_eq("done8_at_end", done8, 64'd1);
    model_run(DW8, DEPTH8, 1, m, fen, fa, 64'(fm), efail, eaddr, edata, ephase, eerr);
    check_eq("pass8", pass8, 64'(!efail));
    check_eq("fail8", fail8, 64'(efail));
    check_eq("fail_addr8", fail_addr8, 64'(eaddr));
    check_eq("fail_data8", fail_data8, edata);
    check_eq("fail_phase8", fail_phase8, 64'(ephase));
    check_eq("err_count8", err_count8, 64'(eerr));
    step();
  endtask

  task automatic ext_write32(input int a, input logic [31:0] d);
    ext_we = 1'b1; ext_addr = AW'(a); ext_wdata = d;
    step();
    ext_we = 1'b0;
    ref_mem[a] = d;
  endtask

  initial begin
    int base;
    int a;
    logic [31:0] fm;
    logic [31:0] expr;
    rst_n = 1'b0;
    start = 1'b0; mode = 2'd0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    fault_en = 1'b0; fault_addr = '0; fault_mask = '0;
    start8 = 1'b0; mode8 = 2'd0; ext_we8 = 1'b0; ext_addr8 = '0; ext_wdata8 = '0;
    fault_en8 = 1'b0; fault_addr8 = '0; fault_mask8 = '0;

    // Reset with random inputs toggling: all status outputs stay zero.
    repeat (3) begin
      step();
      start = 1'($urandom); mode = 2'($urandom); ext_we = 1'($urandom);
      ext_addr = AW'($urandom); ext_wdata = $urandom; start8 = 1'($urandom);
      fault_en = 1'($urandom); fault_mask = $urandom;
      #1;
      check_eq("rst_flags", {busy, done, pass, fail, fail_phase}, 64'd0);
      check_eq("rst_fail_addr", fail_addr, 64'd0);
      check_eq("rst_fail_data", fail_data, 64'd0);
      check_eq("rst_err_count", err_count, 64'd0);
      check_eq("rst_flags8", {busy8, done8, pass8, fail8, fail_phase8, err_count8}, 64'd0);
    end
    start = 1'b0; ext_we = 1'b0; start8 = 1'b0; fault_en = 1'b0; fault_mask = '0;
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) ext_write32(i, $urandom);
    ext_write32(2, 32'h12345678);
    ext_addr = 3'd2;
    #1;
    check_eq("ext_wr_rd", ext_rdata, 64'h12345678);

    // Seed pattern, clean memory.
    run32(0, 1'b0, 0, 32'd0, -1);
    check_eq("seed_pass", pass, 64'd1);
    ext_addr = 3'd3;
    #1;
    check_eq("seed_rd3", ext_rdata, 64'h3ffffffe);

    // Address pattern with a single-bit read fault at address 5.
    run32(2, 1'b1, 5, 32'h1, -1);
    check_eq("addr_fail_data", fail_data, 64'h4);
    check_eq("addr_err", err_count, 64'd2);
    fault_en = 1'b0;
    ext_addr = 3'd5;
    #1;
    check_eq("addr_rd5", ext_rdata, 64'hfffffffa);

    // Checkerboard with start and ext_we pulsed mid-run.
    run32(1, 1'b0, 0, 32'd0, 10);
    ext_addr = 3'd0;
    #1;
    check_eq("check_rd0", ext_rdata, 64'haaaaaaaa);

    // Reset during the inverted write pass.
    fault_en = 1'b0; mode = 2'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 64'd0);
    check_eq("midrst_done", done, 64'd0);
    base = done_cnt;
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("midrst_no_done", 64'(done_cnt), 64'(base));
    run32(int'($urandom_range(0, 3)), 1'b0, 0, 32'd0, -1);
    check_eq("restart_pass", pass, 64'd1);

    // Randomized runs and external accesses against the model.
    repeat (6) begin
      fm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run32(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, DEPTH - 1)), fm, -1);
      repeat (4) begin
        if ($urandom_range(0, 1) == 1) ext_write32(int'($urandom_range(0, DEPTH - 1)), $urandom);
        a = int'($urandom_range(0, DEPTH - 1));
        fault_en = 1'($urandom); fault_addr = AW'($urandom); fault_mask = $urandom;
        ext_addr = AW'(a);
        #1;
        expr = ref_mem[a] ^ ((fault_en && fault_addr == AW'(a)) ? fault_mask : 32'd0);
        check_eq("ext_rand_rd", ext_rdata, 64'(expr));
      end
      fault_en = 1'b0;
    end

    // Narrow instance: walking one, saturating 1-bit error counter.
    run8(3, 1'b1, 9, 8'hff);
    check_eq("w8_fail_data", fail_data8, 64'hfd);
    check_eq("w8_err_sat", err_count8, 64'd1);
    run8(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, DEPTH8 - 1)), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
